// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared register-address constants for the scoreboard
package reg_scoreboard_pkg;
  localparam int REG_ADDR_SIZE = 4;
  localparam int ADDR_W = REG_ADDR_SIZE + 1;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] X0 = '0;
endpackage

// File: rtl/sb_counter.sv
// sb_counter: saturating up/down pending-write counter with zero flag and underflow pulse
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             underflow
);
  assign zero = cnt == '0;
  assign underflow = dec && !inc && zero;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !dec && cnt != '1) cnt <= cnt + CNT_W'(1);
    else if (dec && !inc && !zero) cnt <= cnt - CNT_W'(1);
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write scoreboard producing RAW stall for ID
import reg_scoreboard_pkg::*;
module reg_scoreboard #(
  parameter int NUM_REGS = reg_scoreboard_pkg::NUM_REGS,
  parameter int CNT_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                issue_rd_valid,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic                clear,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                sb_error
);
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_arr;
  logic [NUM_REGS-1:1] uf;
  logic rs1_busy, rs2_busy, full, issue_ev, wb_ev;
  assign cnt_arr[0] = '0;
  assign busy_vec[0] = 1'b0;
  assign rs1_busy = rs1 != X0 && cnt_arr[rs1] > CNT_W'(wb_valid && wb_rd == rs1);
  assign rs2_busy = rs2 != X0 && cnt_arr[rs2] > CNT_W'(wb_valid && wb_rd == rs2);
  assign full = issue_valid && issue_rd_valid && issue_rd != X0 && cnt_arr[issue_rd] == '1;
  assign stall = rs1_busy || rs2_busy || full;
  assign issue_ev = issue_valid && !stall && issue_rd_valid && issue_rd != X0;
  assign wb_ev = wb_valid && wb_rd != X0;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    logic z;
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .inc      (issue_ev && issue_rd == ADDR_W'(i)),
      .dec      (wb_ev && wb_rd == ADDR_W'(i)),
      .clr      (clear),
      .cnt      (cnt_arr[i]),
      .zero     (z),
      .underflow(uf[i])
    );
    assign busy_vec[i] = !z;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) sb_error <= 1'b0;
    else if (|uf) sb_error <= 1'b1;
endmodule
